conv_encoder_r4: RTL

- Radix-4 (2 bits/cycle), rate-1/2, K=9 convolutional encoder with 256 states. It is the transmit-side counterpart of the Viterbi decoder's add-compare-select datapath.
- Accepts information-bit pairs over a valid/ready handshake and emits 4-bit coded symbols through a registered valid/ready output.
- Zero-terminates every frame by appending tail pairs, so the decoder trellis ends in state 0.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_enc_step.sv | 17 +
 rtl/conv_encoder_r4.sv | 109 ++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the radix-4, K=9, rate-1/2 convolutional encoder.
package conv_pkg;

  localparam int STATE_W = 8;
  localparam int RADIX = 4;
  localparam int TAIL_PAIRS = STATE_W / 2;
  localparam logic [STATE_W:0] G0 = 9'o561;
  localparam logic [STATE_W:0] G1 = 9'o753;

  typedef logic [3:0] sym_t;
  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fsm_t;

endpackage

// File: rtl/conv_enc_step.sv
// One trellis bit step: coded pair {c0,c1} and successor state for input u.
module conv_enc_step
  import conv_pkg::*;
(
  input  state_t      state,
  input  logic        u,
  output logic [1:0]  cc,
  output state_t      nxt
);

  logic [STATE_W:0] w;

  assign w   = {state, u};
  assign cc  = {^(w & G0), ^(w & G1)};
  assign nxt = {state[STATE_W-2:0], u};

endmodule

// File: rtl/conv_encoder_r4.sv
// Radix-4 K=9 rate-1/2 convolutional encoder with zero-tail frame termination.
module conv_encoder_r4
  import conv_pkg::*;
#(
  parameter int MAX_FRAME_PAIRS = 1024,
  parameter int CNT_W = $clog2(MAX_FRAME_PAIRS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [3:0]       o_sym,
  output logic             o_last,
  output logic             o_trunc,
  output logic [CNT_W-1:0] o_pair_cnt
);

  localparam int TW = $clog2(TAIL_PAIRS) + 1;

  fsm_t          fsm_q, fsm_d;
  state_t        state_q, mid_st, nxt_st;
  logic [TW-1:0] tail_cnt;
  logic [1:0]    cc0, cc1;
  logic          out_free, accept, tail_go, tail_end;
  logic          forced, in_flush, u0, u1, load;

  assign in_flush = (fsm_q == FLUSH);
  assign out_free = !o_valid || i_ready;
  assign o_ready  = !rst && !in_flush && out_free;
  assign accept   = i_valid && o_ready;
  assign tail_go  = in_flush && out_free;
  assign tail_end = tail_cnt == TW'(TAIL_PAIRS - 1);
  assign load     = accept || tail_go;
  assign forced   = (fsm_q == RUN) &&
                    (o_pair_cnt == CNT_W'(MAX_FRAME_PAIRS - 1));

  // Tail pairs feed zeros so the trellis walks back to state 0.
  assign u0 = in_flush ? 1'b0 : i_data[0];
  assign u1 = in_flush ? 1'b0 : i_data[1];

  conv_enc_step u_step0 (
    .state (state_q),
    .u     (u0),
    .cc    (cc0),
    .nxt   (mid_st)
  );

  conv_enc_step u_step1 (
    .state (mid_st),
    .u     (u1),
    .cc    (cc1),
    .nxt   (nxt_st)
  );

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE, RUN: begin
        if (accept)
          fsm_d = (i_last || forced) ? FLUSH : RUN;
      end
      FLUSH: begin
        if (tail_go && tail_end)
          fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      tail_cnt   <= '0;
      o_valid    <= 1'b0;
      o_sym      <= '0;
      o_last     <= 1'b0;
      o_trunc    <= 1'b0;
      o_pair_cnt <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (load) begin
        o_valid <= 1'b1;
        o_sym   <= {cc0, cc1};
        o_last  <= tail_go && tail_end;
        state_q <= nxt_st;
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (accept) begin
        if (fsm_q == IDLE) begin
          o_pair_cnt <= CNT_W'(1);
          o_trunc    <= 1'b0;
        end else begin
          o_pair_cnt <= o_pair_cnt + CNT_W'(1);
          o_trunc    <= forced && !i_last;
        end
      end
      if (tail_go)
        tail_cnt <= tail_end ? '0 : tail_cnt + TW'(1);
    end
  end

endmodule
